// File: rtl/huffman_decoder_pkg.sv
// huffman_decoder_pkg: state encodings, field widths and default sizing shared by the Huffman codec
package huffman_decoder_pkg;
  typedef enum logic [1:0] {LOAD, DECODE, FLUSH, ERR} state_e;
  localparam int LEN_W = 4;
  localparam int DEF_BIT_WIDTH = 7;
  localparam int DEF_MAX_CODE_LEN = 8;
  localparam int DEF_TABLE_DEPTH = 16;
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_len);
    return len != '0 && int'(len) <= max_len;
  endfunction
endpackage

// File: rtl/huffman_decoder_if.sv
// huffman_decoder_if: table-load, bit-stream and symbol-output handshakes of the Huffman decoder
interface huffman_decoder_if import huffman_decoder_pkg::*; #(
  parameter int bit_width = DEF_BIT_WIDTH
) ();
  logic                 tbl_valid;
  logic                 tbl_ready;
  logic [bit_width:0]   tbl_symbol;
  logic [LEN_W-1:0]     tbl_length;
  logic [bit_width:0]   tbl_code;
  logic                 tbl_last;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 bit_in;
  logic                 bit_last;
  logic                 sym_valid;
  logic                 sym_ready;
  logic [bit_width:0]   sym_out;
  logic                 done;
  logic                 error;
  modport slave (
    input  tbl_valid, tbl_symbol, tbl_length, tbl_code, tbl_last,
    input  bit_valid, bit_in, bit_last, sym_ready,
    output tbl_ready, bit_ready, sym_valid, sym_out, done, error
  );
  modport master (
    output tbl_valid, tbl_symbol, tbl_length, tbl_code, tbl_last,
    output bit_valid, bit_in, bit_last, sym_ready,
    input  tbl_ready, bit_ready, sym_valid, sym_out, done, error
  );
endinterface

// File: rtl/huffman_decoder_match.sv
// huffman_match: parallel comparison of (acc, len) against every table entry, lowest index wins
module huffman_match import huffman_decoder_pkg::*; #(
  parameter int bit_width   = DEF_BIT_WIDTH,
  parameter int table_depth = DEF_TABLE_DEPTH
) (
  input  logic [bit_width:0]     acc,
  input  logic [LEN_W-1:0]       len,
  input  logic [table_depth-1:0] vld,
  input  logic [bit_width:0]     syms  [table_depth],
  input  logic [LEN_W-1:0]       lens  [table_depth],
  input  logic [bit_width:0]     codes [table_depth],
  output logic                   hit,
  output logic [bit_width:0]     symbol
);
  logic [bit_width:0] mask;
  always_comb begin
    mask = '0;
    hit = 1'b0;
    symbol = '0;
    for (int j = 0; j <= bit_width; j++) mask[j] = j < int'(len);
    for (int i = table_depth - 1; i >= 0; i--)
      if (vld[i] && lens[i] == len && ((codes[i] ^ acc) & mask) == '0) begin
        hit = 1'b1;
        symbol = syms[i];
      end
  end
endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: loads a code table, then decodes a one-bit-per-cycle stream into symbols
module huffman_decoder import huffman_decoder_pkg::*; #(
  parameter int bit_width    = DEF_BIT_WIDTH,
  parameter int table_depth  = DEF_TABLE_DEPTH,
  parameter int max_code_len = DEF_MAX_CODE_LEN
) (
  input logic              clock,
  input logic              rst,
  huffman_decoder_if.slave bus
);
  localparam int NW = $clog2(table_depth + 1);
  localparam int IW = table_depth > 1 ? $clog2(table_depth) : 1;
  localparam logic [NW-1:0] FULL = NW'(table_depth);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(max_code_len);

  state_e               state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [bit_width:0]   acc_q, acc_d, acc_nx;
  logic [LEN_W-1:0]     len_q, len_d, len_nx;
  logic                 sym_valid_q, sym_valid_d;
  logic [bit_width:0]   sym_out_q, sym_out_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [bit_width:0]   tsym_q [table_depth];
  logic [bit_width:0]   tsym_d [table_depth];
  logic [LEN_W-1:0]     tlen_q [table_depth];
  logic [LEN_W-1:0]     tlen_d [table_depth];
  logic [bit_width:0]   tcode_q [table_depth];
  logic [bit_width:0]   tcode_d [table_depth];
  logic [table_depth-1:0] vld;
  logic                 hit, bit_rdy, bit_hs;
  logic [bit_width:0]   hit_sym;

  assign bit_rdy       = state_q == DECODE && (!sym_valid_q || bus.sym_ready);
  assign bit_hs        = bit_rdy && bus.bit_valid;
  assign acc_nx        = (acc_q << 1) | {{bit_width{1'b0}}, bus.bit_in};
  assign len_nx        = len_q + LEN_W'(1);
  assign bus.tbl_ready = state_q == LOAD;
  assign bus.bit_ready = bit_rdy;
  assign bus.sym_valid = sym_valid_q;
  assign bus.sym_out   = sym_out_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

  always_comb
    for (int i = 0; i < table_depth; i++) vld[i] = NW'(i) < n_q;

  // Matching looks at the accumulator as it will be after the incoming bit
  huffman_match #(.bit_width(bit_width), .table_depth(table_depth)) u_match (
    .acc(acc_nx), .len(len_nx), .vld(vld),
    .syms(tsym_q), .lens(tlen_q), .codes(tcode_q),
    .hit(hit), .symbol(hit_sym)
  );

  always_comb begin
    state_d = state_q;
    n_d = n_q;
    acc_d = acc_q;
    len_d = len_q;
    sym_valid_d = sym_valid_q && !bus.sym_ready;
    sym_out_d = sym_out_q;
    done_d = 1'b0;
    error_d = error_q;
    tsym_d = tsym_q;
    tlen_d = tlen_q;
    tcode_d = tcode_q;
    case (state_q)
      LOAD: if (bus.tbl_valid) begin
        if (!len_legal(bus.tbl_length, max_code_len) || n_q == FULL) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          tsym_d[n_q[IW-1:0]] = bus.tbl_symbol;
          tlen_d[n_q[IW-1:0]] = bus.tbl_length;
          tcode_d[n_q[IW-1:0]] = bus.tbl_code;
          n_d = n_q + NW'(1);
          state_d = bus.tbl_last ? DECODE : LOAD;
        end
      end
      DECODE: if (bit_hs) begin
        if (hit) begin
          sym_valid_d = 1'b1;
          sym_out_d = hit_sym;
          acc_d = '0;
          len_d = '0;
          state_d = bus.bit_last ? FLUSH : DECODE;
        end else if (bus.bit_last || len_nx == MAX_LEN) begin
          state_d = ERR;
          error_d = 1'b1;
        end else begin
          acc_d = acc_nx;
          len_d = len_nx;
        end
      end
      FLUSH: if (!sym_valid_q || bus.sym_ready) begin
        done_d = 1'b1;
        n_d = '0;
        acc_d = '0;
        len_d = '0;
        state_d = LOAD;
      end
      default: error_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      state_q <= LOAD;
      n_q <= '0;
      acc_q <= '0;
      len_q <= '0;
      sym_valid_q <= 1'b0;
      sym_out_q <= '0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      acc_q <= acc_d;
      len_q <= len_d;
      sym_valid_q <= sym_valid_d;
      sym_out_q <= sym_out_d;
      done_q <= done_d;
      error_q <= error_d;
    end

  // Table contents need no reset: clearing n invalidates every entry
  always_ff @(posedge clock) begin
    tsym_q <= tsym_d;
    tlen_q <= tlen_d;
    tcode_q <= tcode_d;
  end
endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Consumer-side counterpart of the Huffman encoder. Loads the code table emitted by the encoder (symbol, code length, code word per entry), then consumes the compressed stream one bit per cycle and emits decoded symbols. Sits downstream of the compressed-stream source and feeds the raw-symbol sink through a valid/ready handshake.

## Interface
- bit_width, 7: symbol and code-word MSB index; both are bit_width+1 bits wide.
- table_depth, 16: maximum number of code-table entries stored.
- max_code_len, 8: longest legal code, in bits. Must be ≤ bit_width+1.

- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- tbl_valid  in  1  table entry present.
- tbl_ready  out  1  table entry accepted when high together with tbl_valid.
- tbl_symbol  in  bit_width+1  symbol value.
- tbl_length  in  4  code length, 1..max_code_len.
- tbl_code  in  bit_width+1  code word, right-aligned; bit tbl_length-1 is the first bit sent.
- tbl_last  in  1  marks the final table entry.
- bit_valid  in  1  stream bit present.
- bit_ready  out  1  stream bit accepted when high together with bit_valid.
- bit_in  in  1  stream bit, MSB of each code first.
- bit_last  in  1  marks the final stream bit.
- sym_valid  out  1  decoded symbol present.
- sym_ready  in  1  sink accepts the symbol.
- sym_out  out  bit_width+1  decoded symbol.
- done  out  1  one-cycle pulse: stream fully decoded.
- error  out  1  sticky error flag; cleared only by rst.

## Operation
The decoder has four states.

- **LOAD**: entered on reset.
  - tbl_ready=1.
  - Each accepted entry is written at index n, and n increments.
  - An entry with tbl_length of 0 or greater than max_code_len goes to ERR.
  - An accepted entry while n==table_depth goes to ERR.
  - tbl_last accepted with no error goes to DECODE.
- **DECODE**:
  - bit_ready = !sym_valid || sym_ready.
  - On each accepted bit: acc ← {acc[bit_width-1:0], bit_in}, len ← len+1.
  - The new (acc, len) is compared in parallel against all n entries. An entry matches when its length == len and its code[len-1:0] == acc[len-1:0].
  - On a match: the symbol is registered to sym_out, sym_valid=1, acc and len are cleared.
  - If several entries match, the lowest index wins. The table must be prefix-free; violating that is not detected.
  - No match and len==max_code_len goes to ERR.
  - bit_last accepted: if it completes a match, go to FLUSH; otherwise go to ERR.
- **FLUSH**: wait until the last symbol handshakes, then pulse done for one cycle, clear n/acc/len, and go to LOAD.
- **ERR**:
  - error=1.
  - All ready outputs are 0.
  - sym_valid drops after any pending symbol handshakes.
  - Held until rst.
- sym_out is held stable while sym_valid=1 and sym_ready=0.

## Timing
- **Reset values**: state=LOAD, tbl_ready=1, bit_ready=0, sym_valid=0, sym_out=0, done=0, error=0, n=0, acc=0, len=0.
- **Table load**: 1 entry per cycle. DECODE begins the cycle after the tbl_last handshake.
- **Decode latency**: sym_valid rises in the cycle after the handshake of the code's final bit.
- **Throughput**: 1 bit per cycle. With sym_ready held high, a 1-bit code yields 1 symbol per cycle.
- **Simultaneous events**:
  - A symbol handshake and a new completing bit in the same cycle: the old symbol is consumed and the new one loaded, with no bubble.
  - If sym_ready=0 while sym_valid=1, then bit_ready=0.
- **done**: asserted in the cycle after the final symbol's handshake, when the source bit_last has been accepted.
- **Reset mid-operation**: asynchronous clear of all state. The table is invalidated, and any partial symbol and pending output are discarded.

## Structure
- A shared package holds:
  - state encodings LOAD/DECODE/FLUSH/ERR;
  - the length field width (4);
  - default bit_width and max_code_len, also used by the encoder.
- One sub-module, huffman_match: combinational parallel comparator over the table. Inputs are acc, len and the table vectors; outputs are hit and symbol (lowest-index priority).
- The table is register-based: table_depth × (symbol, length, code), so all entries are read in parallel.

## Test plan
- **Basic decode**:
  - Stimulus: table {0x41:len1 code 0b0, 0x42:len2 0b10, 0x43:len2 0b11}, then bits 0,1,0,1,1 with bit_last on the final bit, sym_ready=1.
  - Required response: sym_out 0x41, 0x42, 0x43 on three handshakes, done pulse one cycle later, error=0.
- **Backpressure**:
  - Stimulus: same stream with sym_ready=0 for 5 cycles after the first symbol.
  - Required response: bit_ready=0 and sym_out held at 0x41 throughout; full sequence delivered unchanged afterwards.
- **Unmatched code**:
  - Stimulus: table {0x41:len2 0b00}, then 8 bits of 1.
  - Required response: no sym_valid; error=1 after the 2nd bit… no, after the 8th bit when max_code_len=8 is reached; the ERR state holds until rst.
- **Table faults**:
  - Stimulus: (a) 17 entries with table_depth=16; (b) one entry with tbl_length=0 or 9.
  - Required response: error=1 and tbl_ready=0 the cycle after the offending handshake.
- **Truncated stream**:
  - Stimulus: table from the basic-decode test; bits 1 then bit_last=1 (partial "1").
  - Required response: error=1, no done pulse.
- **Reset mid-decode**:
  - Stimulus: assert rst between clock edges during DECODE with sym_valid=1.
  - Required response: sym_valid=0 and tbl_ready=1 immediately; a reload and re-decode afterwards gives correct symbols.
